// File: rtl/calc_operand_loader.sv
// Operand-entry front end: debounces enter/clear buttons and steps A -> B -> OP -> EXEC,
// capturing operands from a shared switch bank and strobing valid once per complete set.
module calc_operand_loader #(
  parameter int unsigned M   = 6,
  parameter int unsigned DEB = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] sw,
  input  logic         btn_enter,
  input  logic         btn_clear,
  output logic [M-1:0] a,
  output logic [M-1:0] b,
  output logic [3:0]   sel,
  output logic         valid,
  output logic [1:0]   stage
);

  localparam int unsigned CntW = (DEB > 2) ? $clog2(DEB) : 1;

  typedef enum logic [1:0] {
    StA    = 2'd0,
    StB    = 2'd1,
    StOp   = 2'd2,
    StExec = 2'd3
  } state_e;

  logic [1:0] raw;
  logic [1:0] press;
  state_e     state_q;

  assign raw = {btn_clear, btn_enter};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic            s1_q, s2_q, d_q, d_prev_q;
    logic [CntW-1:0] cnt_q;

    // Counter tracks consecutive synced cycles that disagree with the debounced level.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        d_q      <= 1'b0;
        d_prev_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        s1_q     <= raw[i];
        s2_q     <= s1_q;
        d_prev_q <= d_q;
        if (s2_q == d_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntW'(DEB - 1)) begin
          d_q   <= ~d_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end

    assign press[i] = d_q & ~d_prev_q;
  end

  // EXEC ignores all button events; otherwise clear has priority over enter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StA;
      a       <= '0;
      b       <= '0;
      sel     <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state_q == StExec) begin
        state_q <= StA;
      end else if (press[1]) begin
        state_q <= StA;
        a       <= '0;
        b       <= '0;
        sel     <= '0;
      end else if (press[0]) begin
        unique case (state_q)
          StA: begin
            a       <= sw;
            state_q <= StB;
          end
          StB: begin
            b       <= sw;
            state_q <= StOp;
          end
          StOp: begin
            sel     <= sw[3:0];
            state_q <= StExec;
            valid   <= 1'b1;
          end
          default: state_q <= StA;
        endcase
      end
    end
  end

  assign stage = state_q;

endmodule

// File: doc/calc_operand_loader.md
# calc_operand_loader

Operand-entry front end for the switch-driven calculator datapath. It debounces two push-buttons and steps an FSM that captures, from one shared switch bank, operand A, then operand B, then the 4-bit operation select. It then issues a one-cycle `valid` strobe so the downstream ALU/register stage can latch a complete, stable operand set. It drives the calculator's `a`, `b`, `sel` inputs in place of raw switches.

## Interface
- `M`, 6, operand width in bits.
- `DEB`, 500000, debounce length in clock cycles (≥2); benches use 4.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `sw`  input  M  switch bank, shared by all three entry stages.
- `btn_enter`  input  1  raw, asynchronous, bouncing, active-high.
- `btn_clear`  input  1  raw, asynchronous, bouncing, active-high.
- `a`  output  M  captured operand A.
- `b`  output  M  captured operand B.
- `sel`  output  4  captured operation select, taken from `sw[3:0]`, passed through uninverted.
- `valid`  output  1  one-cycle strobe: `a`, `b` and `sel` are complete.
- `stage`  output  2  current FSM state encoding, for LEDs.

## Operation
- **Button conditioning.** Each button has its own 2-flop synchronizer, then a debouncer.
  - The debouncer holds a debounced level `d`, reset value 0.
  - The counter increments while synced input ≠ `d`. It clears to 0 whenever synced input = `d`.
  - When the count reaches DEB, `d` toggles and the counter clears.
  - A press event is the rising edge of `d`, a single-cycle pulse. Release produces no event.
- **FSM states**, encoded on `stage`:
  - S_A=0: on enter, `a`←`sw`, go to S_B.
  - S_B=1: on enter, `b`←`sw`, go to S_OP.
  - S_OP=2: on enter, `sel`←`sw[3:0]`, go to S_EXEC.
  - S_EXEC=3: unconditional. Assert `valid` for this one cycle, then go to S_A. Button events arriving in this cycle are dropped.
- **Clear event**, in any state: go to S_A and zero `a`, `b`, `sel`. `valid` is not asserted.
- **Clear and enter events in the same cycle:** clear wins, enter is discarded.
- **Holding:** `a`, `b`, `sel` keep their values until overwritten by a capture or a clear. Re-entering A after EXEC leaves the old `b`/`sel` visible until they are recaptured.
- **Holding a button** yields exactly one event, regardless of duration.

## Timing
- **Reset values** (rst=0, asynchronous): `a`=0, `b`=0, `sel`=0, `valid`=0, `stage`=0. Synchronizers, debounced levels and counters are all 0.
- **Reset deassertion:** takes effect at the next clock edge.
- **Reset mid-debounce:** discards the partial count. A button still held high after reset produces one press event, DEB+2 edges after release of reset.
- **Latency:** raw button rises before edge k and stays stable.
  - Sync output is 1 after edge k+1.
  - `d`=1 after edge k+1+DEB.
  - The capture register and `stage` update at edge k+DEB+2.
- **`sw` sampling:** `sw` is sampled at the capture edge only; no synchronizer is applied to `sw`.
- **`valid` timing:** `valid` is high for exactly the one cycle following the S_OP capture edge. It is registered, glitch-free, and never asserted for two consecutive cycles.
- **Bounce rejection:** any high or low excursion shorter than DEB consecutive synced cycles does not change `d`.
- **Spacing between entries:** release then re-press needs DEB cycles of stable low before the next press can register.

## Test plan
- **Reset:** assert rst=0 mid-operation with `stage`=2 → all outputs 0 immediately, without waiting for a clock edge; after release, `stage`=0.
- **Full sequence (DEB=4):**
  - Stimulus:
    - `sw`=6'h2A, press enter.
    - `sw`=6'h15, press enter.
    - `sw`=6'h03, press enter.
  - Required response: `a`=2A, `b`=15, `sel`=3; `valid` high for one cycle exactly 1 cycle after the third capture; `stage` returns to 0.
- **Bounce rejection (DEB=4):** enter toggles 1,0,1,0 with 2-cycle pulses, then held high 10 cycles → exactly one capture, at edge k+6 measured from the start of the stable-high period.
- **Clear:** in S_B with `a`=2A, press clear → `a`=0, `stage`=0, no `valid`. Then assert clear and enter in the same cycle → clear wins, `a` stays 0.
- **Long hold:** hold enter for 100 cycles in S_A → single capture, `stage`=1, no further advance.
- **Event during EXEC:** an enter event landing in the S_EXEC cycle is dropped → `stage`=0 afterwards and `a` is unchanged.
